// File: rtl/bool_reduce_pkg.sv
// bool_reduce_pkg: shared mode encodings and popcount helper for the
// bool_reduce_pipe block and its combinational core.
package bool_reduce_pkg;

   localparam logic [1:0] MODE_AND = 2'd0;
   localparam logic [1:0] MODE_OR  = 2'd1;
   localparam logic [1:0] MODE_XOR = 2'd2;
   localparam logic [1:0] MODE_MAJ = 2'd3;

   // Number of ones in a word of up to 64 bits; narrower callers zero-extend.
   function automatic logic [6:0] f_popcount(input logic [63:0] v);
      logic [6:0] c;
      c = '0;
      for (int i = 0; i < 64; i++) begin
         c = c + 7'(v[i]);
      end
      return c;
   endfunction

endpackage

// File: rtl/bool_reduce_core.sv
// bool_reduce_core: purely combinational evaluation of one word in one mode.
// Produces the selected boolean function and the popcount of the word.
module bool_reduce_core
   import bool_reduce_pkg::*;
#(
   parameter int WIDTH = 5,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] data,
   input  logic [1:0]       mode,
   output logic             f,
   output logic [CNT_W-1:0] pop
);

   // Majority threshold: strictly more than half, so an even-width tie is 0.
   localparam logic [CNT_W-1:0] HALF = CNT_W'(WIDTH / 2);

   // Evaluate popcount and the mode-selected reduction.
   always_comb begin
      pop = CNT_W'(f_popcount(64'(data)));
      f   = 1'b0;
      unique case (mode)
         MODE_AND: f = &data;
         MODE_OR:  f = |data;
         MODE_XOR: f = ^data;
         MODE_MAJ: f = (pop > HALF);
      endcase
   end

endmodule

// File: rtl/bool_reduce_pipe.sv
// bool_reduce_pipe: two-stage valid/ready pipeline evaluating AND/OR/XOR/MAJ
// over a WIDTH-bit word and reporting its popcount.
// Optional feature macro: BOOL_REDUCE_HITCNT_EN compiles in the 16-bit
// saturating hit_count register and its hit_clr; otherwise hit_count is 0.
module bool_reduce_pipe
   import bool_reduce_pkg::*;
#(
   parameter int WIDTH = 5,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_f,
   output logic [CNT_W-1:0] out_pop,
   output logic [15:0]      hit_count,
   input  logic             hit_clr
);

   logic             s1_valid_reg;
   logic [WIDTH-1:0] s1_data_reg;
   logic [1:0]       s1_mode_reg;
   logic [CNT_W-1:0] s1_pop_reg;
   logic             s1_and_reg;
   logic             s1_or_reg;
   logic             s1_xor_reg;

   logic             out_valid_reg;
   logic             out_f_reg;
   logic [CNT_W-1:0] out_pop_reg;

   logic             s1_adv;
   logic             s2_adv;
   logic             f_next;
   logic             core_f;
   logic [CNT_W-1:0] core_pop_unused;

   // Handshake: stage 2 moves when empty or drained; stage 1 follows it.
   // in_ready is combinational from out_ready (no skid buffer) and held low in reset.
   always_comb begin
      s2_adv   = !out_valid_reg || out_ready;
      s1_adv   = !s1_valid_reg || s2_adv;
      in_ready = s1_adv && rst_n;
   end

   // Stage 1: capture the beat with its mode, popcount and basic reductions.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_reg <= 1'b0;
         s1_data_reg  <= '0;
         s1_mode_reg  <= MODE_AND;
         s1_pop_reg   <= '0;
         s1_and_reg   <= 1'b0;
         s1_or_reg    <= 1'b0;
         s1_xor_reg   <= 1'b0;
      end else if (s1_adv) begin
         s1_valid_reg <= in_valid;
         if (in_valid) begin
            s1_data_reg <= in_data;
            s1_mode_reg <= in_mode;
            s1_pop_reg  <= CNT_W'(f_popcount(64'(in_data)));
            s1_and_reg  <= &in_data;
            s1_or_reg   <= |in_data;
            s1_xor_reg  <= ^in_data;
         end
      end
   end

   // Majority comes from the shared core evaluated on the stage-1 word.
   bool_reduce_core #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_core (
      .data (s1_data_reg),
      .mode (s1_mode_reg),
      .f    (core_f),
      .pop  (core_pop_unused)
   );

   // Stage-2 function select by the captured mode.
   always_comb begin
      f_next = 1'b0;
      unique case (s1_mode_reg)
         MODE_AND: f_next = s1_and_reg;
         MODE_OR:  f_next = s1_or_reg;
         MODE_XOR: f_next = s1_xor_reg;
         MODE_MAJ: f_next = core_f;
      endcase
   end

   // Stage 2: output register; holds its value while stalled by out_ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_reg <= 1'b0;
         out_f_reg     <= 1'b0;
         out_pop_reg   <= '0;
      end else if (s2_adv) begin
         out_valid_reg <= s1_valid_reg;
         if (s1_valid_reg) begin
            out_f_reg   <= f_next;
            out_pop_reg <= s1_pop_reg;
         end
      end
   end

   assign out_valid = out_valid_reg;
   assign out_f     = out_f_reg;
   assign out_pop   = out_pop_reg;

`ifdef BOOL_REDUCE_HITCNT_EN
   logic [15:0] hit_count_reg;

   // Saturating count of delivered f=1 results; clear beats increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_count_reg <= '0;
      end else if (hit_clr) begin
         hit_count_reg <= '0;
      end else if (out_valid_reg && out_ready && out_f_reg && (hit_count_reg != 16'hFFFF)) begin
         hit_count_reg <= hit_count_reg + 16'd1;
      end
   end

   assign hit_count = hit_count_reg;
`else
   logic unused_hit_clr;

   assign unused_hit_clr = hit_clr;
   assign hit_count      = 16'h0000;
`endif

endmodule

// File: tb/tb_bool_reduce_pipe.sv
// tb_bool_reduce_pipe: table-driven mode sweep, flow-control sequences,
// reset mid-flight, hit counter traffic and randomized scoreboard traffic.
module tb_bool_reduce_pipe;

   localparam int W = 5;
   localparam int CW = 3;
`ifdef BOOL_REDUCE_HITCNT_EN
   localparam bit HIT_EN = 1'b1;
`else
   localparam bit HIT_EN = 1'b0;
`endif

   typedef struct {
      logic [1:0]    mode;
      logic [W-1:0]  data;
      logic          f;
      logic [CW-1:0] pop;
   } vec_t;

   typedef struct {
      logic          f;
      logic [CW-1:0] pop;
      int            cyc;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic [1:0]    in_mode;
   logic          out_valid;
   logic          out_ready;
   logic          out_f;
   logic [CW-1:0] out_pop;
   logic [15:0]   hit_count;
   logic          hit_clr;

   logic [W-1:0]  rc_data;
   logic [1:0]    rc_mode;
   logic          rc_f;
   logic [CW-1:0] rc_pop;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   accepts = 0;
   int   outs = 0;
   int   hit_model = 0;
   bit   lat_chk = 1'b0;
   bit   use_ovr = 1'b0;
   logic          ovr_f;
   logic [CW-1:0] ovr_pop;

   bool_reduce_pipe #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_f     (out_f),
      .out_pop   (out_pop),
      .hit_count (hit_count),
      .hit_clr   (hit_clr)
   );

   bool_reduce_core #(.WIDTH(W)) ref_core (
      .data (rc_data),
      .mode (rc_mode),
      .f    (rc_f),
      .pop  (rc_pop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: count the ones, then apply the mode rule to the count.
   function automatic void model(input logic [1:0] m, input logic [W-1:0] d,
                                 output logic f, output logic [CW-1:0] p);
      int n;
      n = 0;
      for (int i = 0; i < W; i++) n += int'(d[i]);
      p = CW'(n);
      case (m)
         2'd0:    f = (n == W);
         2'd1:    f = (n != 0);
         2'd2:    f = (n % 2 == 1);
         default: f = (n * 2 > W);
      endcase
   endfunction

   // One cycle: settle, score both handshakes, then advance to the next negedge.
   task automatic step();
      exp_t          e;
      logic          mf;
      logic [CW-1:0] mp;
      #1;
      chk("hit_count", int'(hit_count), HIT_EN ? hit_model : 0);
      if (out_valid && out_ready) begin
         outs++;
         if (q.size() == 0) begin
            chk("spurious_out", 1, 0);
         end else begin
            e = q.pop_front();
            chk("out_f", int'(out_f), int'(e.f));
            chk("out_pop", int'(out_pop), int'(e.pop));
            if (lat_chk) chk("latency", cyc - e.cyc, 2);
            if (!hit_clr && e.f && hit_model < 65535) hit_model++;
         end
      end
      if (hit_clr) hit_model = 0;
      if (in_valid && in_ready) begin
         accepts++;
         model(in_mode, in_data, mf, mp);
         if (use_ovr) begin
            mf = ovr_f;
            mp = ovr_pop;
         end
         q.push_back('{f: mf, pop: mp, cyc: cyc});
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic drain(input int n);
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      vec_t          tab[8];
      logic [W-1:0]  bp[4];
      logic          mf;
      logic [CW-1:0] mp;
      logic          ref_f;
      logic [CW-1:0] ref_pop;
      int            k;
      int            a0;
      int            nsat;
      bit            have_ref;

      tab[0] = '{2'd0, 5'b11111, 1'b1, 3'd5};
      tab[1] = '{2'd0, 5'b11110, 1'b0, 3'd4};
      tab[2] = '{2'd1, 5'b00000, 1'b0, 3'd0};
      tab[3] = '{2'd1, 5'b00001, 1'b1, 3'd1};
      tab[4] = '{2'd2, 5'b00010, 1'b1, 3'd1};
      tab[5] = '{2'd2, 5'b00110, 1'b0, 3'd2};
      tab[6] = '{2'd3, 5'b00110, 1'b0, 3'd2};
      tab[7] = '{2'd3, 5'b00111, 1'b1, 3'd3};
      bp[0] = 5'b10101; bp[1] = 5'b11100; bp[2] = 5'b00011; bp[3] = 5'b11111;

      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = '0;
      out_ready = 1'b0; hit_clr = 1'b0; rc_data = '0; rc_mode = '0;

      // Reset state
      #2;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_f", int'(out_f), 0);
      chk("rst_out_pop", int'(out_pop), 0);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_hit_count", int'(hit_count), 0);

      // Standalone core against the reference model
      for (int i = 0; i < 40; i++) begin
         rc_data = W'($urandom);
         rc_mode = 2'($urandom);
         #1;
         model(rc_mode, rc_data, mf, mp);
         chk("core_f", int'(rc_f), int'(mf));
         chk("core_pop", int'(rc_pop), int'(mp));
      end

      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", int'(in_ready), 1);

      // Mode sweep from the table, out_ready held high
      out_ready = 1'b1;
      lat_chk = 1'b1;
      use_ovr = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_mode  = tab[i].mode;
         in_data  = tab[i].data;
         ovr_f    = tab[i].f;
         ovr_pop  = tab[i].pop;
         step();
      end
      use_ovr = 1'b0;
      drain(3);
      lat_chk = 1'b0;

      // Backpressure: 5 stalled cycles offering 4 beats
      out_ready = 1'b0;
      accepts = 0;
      k = 0;
      have_ref = 1'b0;
      ref_f = 1'b0;
      ref_pop = '0;
      in_mode = 2'd3;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data = bp[k];
         a0 = accepts;
         step();
         if (accepts > a0) k++;
         if (out_valid) begin
            if (have_ref) begin
               chk("bp_hold_f", int'(out_f), int'(ref_f));
               chk("bp_hold_pop", int'(out_pop), int'(ref_pop));
            end else begin
               ref_f = out_f;
               ref_pop = out_pop;
               have_ref = 1'b1;
            end
         end
      end
      chk("bp_accepts", accepts, 2);
      chk("bp_in_ready", int'(in_ready), 0);
      out_ready = 1'b1;
      outs = 0;
      for (int i = 0; i < 4; i++) begin
         if (k < 4) begin
            in_valid = 1'b1;
            in_data = bp[k];
         end else begin
            in_valid = 1'b0;
         end
         a0 = accepts;
         step();
         if (accepts > a0) k++;
      end
      chk("bp_outs_no_gap", outs, 4);
      drain(2);

      // Simultaneous in/out handshake on a full pipe
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_data = W'($urandom); in_mode = 2'($urandom);
         step();
      end
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1; in_data = W'($urandom); in_mode = 2'($urandom);
         #1;
         chk("full_in_ready", int'(in_ready), 1);
         chk("full_out_valid", int'(out_valid), 1);
         step();
      end
      drain(3);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_data   = W'($urandom);
         in_mode   = 2'($urandom);
         hit_clr   = ($urandom_range(0, 49) == 0);
         step();
      end
      hit_clr = 1'b0;
      out_ready = 1'b1;
      drain(4);
      chk("rand_drained", q.size(), 0);

      // Reset asserted between edges with both stages full
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_data = 5'b11111; in_mode = 2'd1;
         step();
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_in_ready", int'(in_ready), 0);
      q.delete();
      hit_model = 0;
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("midrst_no_stale", int'(out_valid), 0);
      end
      chk("midrst_hit_count", int'(hit_count), 0);

      // hit_count: 3 hits and 1 miss
      in_mode = 2'd1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data = (i == 3) ? 5'b00000 : 5'b00001;
         step();
      end
      drain(3);
      chk("hit_three", int'(hit_count), HIT_EN ? 3 : 0);

      // Clear in the same cycle as an f=1 delivery
      in_valid = 1'b1; in_data = 5'b00001; in_mode = 2'd1;
      step();
      in_valid = 1'b0;
      step();
      hit_clr = 1'b1;
      chk("clr_cycle_delivery", int'(out_valid), 1);
      step();
      hit_clr = 1'b0;
      step();
      chk("hit_clr_wins", int'(hit_count), 0);

      // Saturation: 65536 f=1 deliveries
      nsat = HIT_EN ? 65536 : 16;
      in_mode = 2'd0; in_data = 5'b11111;
      for (int i = 0; i < nsat; i++) begin
         in_valid = 1'b1;
         step();
      end
      drain(3);
      chk("hit_saturate", int'(hit_count), HIT_EN ? 65535 : 0);
      chk("final_drained", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
